// File: rtl/plru_tree_alloc.sv
// plru_tree_alloc: tree pseudo-LRU victim allocator with invalid-first selection and refill handshake.
// Optional entry locking is enabled with `define MMS_PLRU_LOCK_EN.
module plru_tree_alloc #(
  parameter int ENTRIES = 32,
  localparam int IDX_W = $clog2(ENTRIES)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic [ENTRIES-1:0] entry_valid_i,
  input  logic               hit_vld_i,
  input  logic [ENTRIES-1:0] hit_onehot_i,
  input  logic               refill_req_i,
  input  logic               refill_vld_i,
`ifdef MMS_PLRU_LOCK_EN
  input  logic [ENTRIES-1:0] lock_i,
`endif
  output logic               victim_vld_o,
  output logic [IDX_W-1:0]   victim_idx_o,
  output logic [ENTRIES-1:0] victim_onehot_o,
  output logic               hit_err_o,
  output logic [ENTRIES-2:0] plru_state_o
);
  localparam int HW = 2 * ENTRIES;
  typedef enum logic {IDLE, HELD} state_e;
  state_e state_q, state_d;
  logic [ENTRIES-2:0] tree_q, tree_d;
  logic [IDX_W-1:0] vic_q, vic_d, inv_idx, walk_idx, sel_idx, hit_idx;
  logic err_q, err_d, inv_found, hit_ok, commit, dir;
  logic [ENTRIES-1:0] lock, avail;
  logic [HW-1:0] full, tree_x, tree_nx;
  logic [IDX_W:0] node;
`ifdef MMS_PLRU_LOCK_EN
  assign lock = lock_i;
`else
  assign lock = '0;
`endif
  assign tree_x = HW'(tree_q);
  // Heap-indexed walk over a padded vector so node indices are exactly IDX_W+1 bits wide.
  function automatic logic [HW-1:0] touch(input logic [HW-1:0] t, input logic [IDX_W-1:0] e);
    logic [HW-1:0] r;
    logic [IDX_W:0] n;
    logic [IDX_W-1:0] s;
    r = t;
    n = '0;
    s = e;
    for (int l = 0; l < IDX_W; l++) begin
      r[n] = ~s[IDX_W-1];
      n = {n[IDX_W-1:0], 1'b1} + {{IDX_W{1'b0}}, s[IDX_W-1]};
      s = s << 1;
    end
    return r;
  endfunction
  always_comb begin : select
    full = '0;
    full[ENTRIES-1 +: ENTRIES] = lock;
    for (int i = ENTRIES - 2; i >= 0; i--) full[i] = full[2*i+1] & full[2*i+2];
    node = '0;
    dir = 1'b0;
    for (int l = 0; l < IDX_W; l++) begin
      dir = tree_x[node];
      dir = full[{node[IDX_W-1:0], 1'b1} + {{IDX_W{1'b0}}, dir}] ? ~dir : dir;
      node = {node[IDX_W-1:0], 1'b1} + {{IDX_W{1'b0}}, dir};
    end
    walk_idx = IDX_W'(node + 1'b1);
    avail = ~entry_valid_i & ~lock;
    inv_found = |avail;
    inv_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) inv_idx = avail[i] ? IDX_W'(i) : inv_idx;
    hit_idx = '0;
    for (int i = 0; i < ENTRIES; i++) hit_idx = hit_onehot_i[i] ? IDX_W'(i) : hit_idx;
    sel_idx = inv_found ? inv_idx : walk_idx;
  end
  always_comb begin : next_state
    commit = (state_q == HELD) & refill_vld_i;
    hit_ok = hit_vld_i & $onehot(hit_onehot_i);
    tree_nx = commit ? touch(tree_x, vic_q) : tree_x;
    tree_nx = hit_ok ? touch(tree_nx, hit_idx) : tree_nx;
    tree_d = flush_i ? '0 : tree_nx[ENTRIES-2:0];
    err_d = ~flush_i & hit_vld_i & ~$onehot(hit_onehot_i);
    state_d = flush_i ? IDLE :
              (state_q == IDLE) ? ((refill_req_i & ~full[0]) ? HELD : IDLE) :
              (refill_vld_i ? IDLE : HELD);
    vic_d = (~flush_i & (state_q == IDLE) & refill_req_i & ~full[0]) ? sel_idx : vic_q;
  end
  always_comb begin : outputs
    victim_vld_o = state_q == HELD;
    victim_idx_o = vic_q;
    victim_onehot_o = (state_q == HELD) ? ENTRIES'(1) << vic_q : '0;
    hit_err_o = err_q;
    plru_state_o = tree_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      tree_q <= '0;
      vic_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tree_q <= tree_d;
      vic_q <= vic_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_plru_tree_alloc.sv
// tb_plru_tree_alloc: directed scenarios plus randomized traffic checked against a per-level PLRU model.
module tb_plru_tree_alloc;
  localparam int N = 8;
  localparam int L = 3;
  logic clk = 1'b0;
  logic rst, flush, hit_vld, req, rvld;
  logic [N-1:0] valid, hit_oh;
`ifdef MMS_PLRU_LOCK_EN
  logic [N-1:0] lock;
`endif
  logic vvld, herr;
  logic [L-1:0] vidx;
  logic [N-1:0] voh;
  logic [N-2:0] pst;
  int tests = 0;
  int fails = 0;
  bit mt[N-1], nt[N-1];
  bit mheld, nheld, merr, nerr;
  int mvic, nvic;

  always #5 clk = ~clk;

  plru_tree_alloc #(.ENTRIES(N)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .entry_valid_i(valid),
    .hit_vld_i(hit_vld), .hit_onehot_i(hit_oh), .refill_req_i(req), .refill_vld_i(rvld),
`ifdef MMS_PLRU_LOCK_EN
    .lock_i(lock),
`endif
    .victim_vld_o(vvld), .victim_idx_o(vidx), .victim_onehot_o(voh),
    .hit_err_o(herr), .plru_state_o(pst)
  );

  function automatic logic [N-1:0] lockv();
`ifdef MMS_PLRU_LOCK_EN
    return lock;
`else
    return '0;
`endif
  endfunction

  // Level l holds 2^l nodes; entry e sits under node e>>(L-l) at that level.
  function automatic void touch_nt(int e);
    for (int l = 0; l < L; l++) nt[(1 << l) - 1 + (e >> (L - l))] = !((e >> (L - 1 - l)) & 1);
  endfunction

  function automatic bit range_locked(int lo, int cnt);
    logic [N-1:0] lk;
    lk = lockv();
    for (int i = lo; i < lo + cnt; i++) if (!lk[i]) return 0;
    return 1;
  endfunction

  function automatic int mvictim();
    int p, d;
    logic [N-1:0] lk;
    lk = lockv();
    for (int i = 0; i < N; i++) if (!valid[i] && !lk[i]) return i;
    p = 0;
    for (int l = 0; l < L; l++) begin
      d = mt[(1 << l) - 1 + p];
      if (range_locked((2 * p + d) << (L - 1 - l), 1 << (L - 1 - l))) d = 1 - d;
      p = 2 * p + d;
    end
    return p;
  endfunction

  function automatic logic [N-2:0] mstate();
    logic [N-2:0] s;
    for (int i = 0; i < N - 1; i++) s[i] = mt[i];
    return s;
  endfunction

  task automatic cyc();
    int sel;
    bit commit;
    if (rst) begin
      foreach (nt[i]) nt[i] = 0;
      nheld = 0; nvic = 0; nerr = 0;
    end else if (flush) begin
      foreach (nt[i]) nt[i] = 0;
      nheld = 0; nvic = mvic; nerr = 0;
    end else begin
      sel = mvictim();
      nt = mt;
      commit = mheld && rvld;
      if (commit) touch_nt(mvic);
      if (hit_vld && $countones(hit_oh) == 1) touch_nt($clog2(hit_oh));
      nerr = hit_vld && $countones(hit_oh) != 1;
      nheld = mheld; nvic = mvic;
      if (!mheld && req && lockv() != '1) begin
        nheld = 1; nvic = sel;
      end else if (commit) nheld = 0;
    end
    @(posedge clk);
    #1;
    mt = nt; mheld = nheld; mvic = nvic; merr = nerr;
  endtask

  task automatic idle();
    rst = 0; flush = 0; hit_vld = 0; hit_oh = '0; req = 0; rvld = 0;
`ifdef MMS_PLRU_LOCK_EN
    lock = '0;
`endif
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    cyc();
    rst = 0;
  endtask

  task automatic test_reset();
    idle();
    valid = '1;
    rst = 1; hit_vld = 1; hit_oh = 8'h03; req = 1;
    cyc(); cyc();
    tests += 5;
    if (vvld !== 1'b0) begin fails++; $display("FAIL reset_vld got %0b want 0", vvld); end
    if (vidx !== 3'd0) begin fails++; $display("FAIL reset_idx got %0d want 0", vidx); end
    if (voh !== 8'h00) begin fails++; $display("FAIL reset_onehot got %h want 00", voh); end
    if (herr !== 1'b0) begin fails++; $display("FAIL reset_err got %0b want 0", herr); end
    if (pst !== 7'h00) begin fails++; $display("FAIL reset_state got %h want 00", pst); end
    idle();
  endtask

  task automatic test_invalid_first();
    do_reset();
    valid = 8'b0000_0111;
    req = 1; cyc(); req = 0;
    tests += 3;
    if (vvld !== 1'b1) begin fails++; $display("FAIL inv_vld got %0b want 1", vvld); end
    if (vidx !== 3'd3) begin fails++; $display("FAIL inv_idx got %0d want 3", vidx); end
    if (voh !== 8'h08) begin fails++; $display("FAIL inv_onehot got %h want 08", voh); end
    rvld = 1; cyc(); rvld = 0;
    tests += 3;
    if (vvld !== 1'b0) begin fails++; $display("FAIL inv_commit_vld got %0b want 0", vvld); end
    if (voh !== 8'h00) begin fails++; $display("FAIL inv_commit_onehot got %h want 00", voh); end
    if (pst !== 7'h01) begin fails++; $display("FAIL inv_commit_state got %h want 01", pst); end
    rvld = 1; cyc(); rvld = 0;
    tests++;
    if (pst !== 7'h01) begin fails++; $display("FAIL idle_commit_state got %h want 01", pst); end
  endtask

  task automatic test_tree_walk();
    do_reset();
    valid = '1;
    hit_vld = 1; hit_oh = 8'h01; cyc(); hit_vld = 0;
    req = 1; cyc(); req = 0;
    tests++;
    if (vidx !== 3'd4 || vvld !== 1'b1) begin fails++; $display("FAIL walk_a got vld=%0b idx=%0d want vld=1 idx=4", vvld, vidx); end
    rvld = 1; cyc(); rvld = 0;
    hit_vld = 1; hit_oh = 8'h10; cyc(); hit_vld = 0;
    tests++;
    if (pst !== 7'h2E) begin fails++; $display("FAIL walk_state got %h want 2e", pst); end
    req = 1; cyc(); req = 0;
    tests++;
    if (vidx !== 3'd2 || vvld !== 1'b1) begin fails++; $display("FAIL walk_b got vld=%0b idx=%0d want vld=1 idx=2", vvld, vidx); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    valid = '1;
    req = 1; cyc(); req = 0;
    tests++;
    if (vidx !== 3'd0 || vvld !== 1'b1) begin fails++; $display("FAIL simul_first got vld=%0b idx=%0d want vld=1 idx=0", vvld, vidx); end
    rvld = 1; hit_vld = 1; hit_oh = 8'h01; req = 1; cyc(); idle();
    tests++;
    if (vvld !== 1'b0) begin fails++; $display("FAIL simul_commit_vld got %0b want 0", vvld); end
    req = 1; cyc(); req = 0;
    tests++;
    if (vidx !== 3'd4 || vvld !== 1'b1) begin fails++; $display("FAIL simul_next got vld=%0b idx=%0d want vld=1 idx=4", vvld, vidx); end
  endtask

  task automatic test_hit_err();
    logic [N-1:0] pats [2];
    pats[0] = 8'h03;
    pats[1] = 8'h00;
    foreach (pats[k]) begin
      do_reset();
      valid = '1;
      hit_vld = 1; hit_oh = pats[k]; cyc(); idle();
      tests += 2;
      if (herr !== 1'b1) begin fails++; $display("FAIL hit_err_pulse[%0d] got %0b want 1", k, herr); end
      if (pst !== 7'h00) begin fails++; $display("FAIL hit_err_state[%0d] got %h want 00", k, pst); end
      cyc();
      tests++;
      if (herr !== 1'b0) begin fails++; $display("FAIL hit_err_clear[%0d] got %0b want 0", k, herr); end
    end
  endtask

  task automatic test_hold_flush();
    do_reset();
    valid = '1;
    req = 1; cyc();
    valid[5] = 1'b0;
    hit_vld = 1; hit_oh = 8'h04; cyc();
    hit_oh = 8'h80; cyc(); idle();
    tests += 2;
    if (vvld !== 1'b1) begin fails++; $display("FAIL hold_vld got %0b want 1", vvld); end
    if (vidx !== 3'd0) begin fails++; $display("FAIL hold_idx got %0d want 0", vidx); end
    flush = 1; hit_vld = 1; hit_oh = 8'h02; rvld = 1; req = 1; cyc(); idle();
    tests += 2;
    if (vvld !== 1'b0) begin fails++; $display("FAIL flush_vld got %0b want 0", vvld); end
    if (pst !== 7'h00) begin fails++; $display("FAIL flush_state got %h want 00", pst); end
    valid = '1;
  endtask

`ifdef MMS_PLRU_LOCK_EN
  task automatic test_lock();
    do_reset();
    valid = '1;
    lock = 8'h0F; req = 1; cyc(); req = 0;
    tests++;
    if (vidx !== 3'd4 || vvld !== 1'b1) begin fails++; $display("FAIL lock_half got vld=%0b idx=%0d want vld=1 idx=4", vvld, vidx); end
    rvld = 1; cyc(); rvld = 0;
    lock = 8'hFF; req = 1; cyc(); req = 0;
    tests++;
    if (vvld !== 1'b0) begin fails++; $display("FAIL lock_all got %0b want 0", vvld); end
    idle();
  endtask
`endif

  task automatic test_random();
    logic [N-1:0] exp_oh;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      rst = $urandom_range(63) == 0;
      flush = $urandom_range(15) == 0;
      req = $urandom_range(2) == 0;
      rvld = $urandom_range(2) == 0;
      hit_vld = $urandom_range(1) == 1;
      hit_oh = ($urandom_range(3) == 0) ? N'($urandom) : N'(1) << $urandom_range(N - 1);
      valid = ($urandom_range(1) == 1) ? '1 : N'($urandom) | N'($urandom);
`ifdef MMS_PLRU_LOCK_EN
      lock = ($urandom_range(3) == 0) ? N'($urandom) : '0;
`endif
      cyc();
      exp_oh = mheld ? N'(1) << mvic : '0;
      tests += 4;
      if (vvld !== mheld) begin fails++; $display("FAIL rnd_vld[%0d] got %0b want %0b", k, vvld, mheld); end
      if (voh !== exp_oh) begin fails++; $display("FAIL rnd_onehot[%0d] got %h want %h", k, voh, exp_oh); end
      if (herr !== merr) begin fails++; $display("FAIL rnd_err[%0d] got %0b want %0b", k, herr, merr); end
      if (pst !== mstate()) begin fails++; $display("FAIL rnd_state[%0d] got %h want %h", k, pst, mstate()); end
      if (mheld) begin
        tests++;
        if (vidx !== L'(mvic)) begin fails++; $display("FAIL rnd_idx[%0d] got %0d want %0d", k, vidx, mvic); end
      end
    end
    idle();
  endtask

  initial begin
    idle();
    valid = '1;
    rst = 1;
    test_reset();
    test_invalid_first();
    test_tree_walk();
    test_simultaneous();
    test_hit_err();
    test_hold_flush();
`ifdef MMS_PLRU_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
